// File: rtl/ctrl_pipe.sv
//------------------------------------------------------------------------------
// ctrl_pipe
//
// Carries a decoded control bundle from Decode through STAGES identical
// pipeline registers (stage 0 = Execute, stage STAGES-1 = Writeback). Each
// stage holds {Ctrl, Valid, Rd, RegWrite}. A stall holds a stage, a flush
// loads a bubble, and a stage whose upstream neighbour is stalled loads a
// bubble so the held instruction is not duplicated. The block also produces
// a load-use stall request and a "pending write" indication for the hazard
// unit.
//
// Ports:
//   clk            clock
//   reset          asynchronous active-low reset
//   StallS/FlushS  per-stage stall / flush, bit i = stage i
//   CtrlD, ValidD  control bundle and valid flag from Decode
//   RdD, RegWriteD destination register and write enable from Decode
//   Rs1D, Rs2D     Decode source registers (load-use check)
//   CtrlS          per-stage bundles, stage i at [i*CTRLW +: CTRLW]
//   ValidS         per-stage valid
//   RdS            per-stage destination register, stage i at [i*REGW +: REGW]
//   RegWriteS      per-stage register-write enable
//   LoadUseStallD  Decode must stall (load in stage 0 feeds a Decode source)
//   PendingD       PENDBIT set in Decode or in any valid stage
//
// Optional feature (macro CTRL_PIPE_PERF_EN):
//   BubbleCount    edges on which any stage i>0 loaded a flush or auto bubble
//   RetireCount    edges on which the last stage held a valid entry and moved
//   Both saturate at 32'hFFFF_FFFF. Without the macro they do not exist.
//------------------------------------------------------------------------------
module ctrl_pipe #(
   parameter int STAGES   = 3,
   parameter int CTRLW    = 27,
   parameter int REGW     = 5,
   parameter int PENDBIT  = 0,
   parameter int MEMRDBIT = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [STAGES-1:0]         StallS,
   input  logic [STAGES-1:0]         FlushS,
   input  logic [CTRLW-1:0]          CtrlD,
   input  logic                      ValidD,
   input  logic [REGW-1:0]           RdD,
   input  logic                      RegWriteD,
   input  logic [REGW-1:0]           Rs1D,
   input  logic [REGW-1:0]           Rs2D,
   output logic [STAGES*CTRLW-1:0]   CtrlS,
   output logic [STAGES-1:0]         ValidS,
   output logic [STAGES*REGW-1:0]    RdS,
   output logic [STAGES-1:0]         RegWriteS,
   output logic                      LoadUseStallD,
   output logic                      PendingD
`ifdef CTRL_PIPE_PERF_EN
   ,
   output logic [31:0]               BubbleCount,
   output logic [31:0]               RetireCount
`endif
);

   // Stage registers, packed so stage i maps onto the flat output slices.
   logic [STAGES-1:0][CTRLW-1:0] ctrl_q, ctrl_d;
   logic [STAGES-1:0][REGW-1:0]  rd_q,   rd_d;
   logic [STAGES-1:0]            valid_q, valid_d;
   logic [STAGES-1:0]            rw_q,    rw_d;

   // Input record of every stage: Decode for stage 0, stage i-1 otherwise.
   logic [STAGES-1:0][CTRLW-1:0] in_ctrl_s;
   logic [STAGES-1:0][REGW-1:0]  in_rd_s;
   logic [STAGES-1:0]            in_valid_s;
   logic [STAGES-1:0]            in_rw_s;

   // Bit i set when the stage feeding stage i is stalled (never for stage 0).
   logic [STAGES-1:0]            up_stall_s;

   // Set when a stage i>0 loads a bubble on this edge.
   logic                         bubble_evt_s;
   // Set when the last stage holds a valid entry that moves on this edge.
   logic                         retire_evt_s;

   // Saturating increment shared by the performance counters.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
      logic [31:0] res;
      if (en && (val != 32'hFFFF_FFFF)) begin
         res = val + 32'd1;
      end else begin
         res = val;
      end
      return res;
   endfunction

   // Destination register matches a source register and is not x0.
   function automatic logic rd_hits(input logic [REGW-1:0] rd,
                                    input logic [REGW-1:0] rs1,
                                    input logic [REGW-1:0] rs2);
      logic hit;
      if (rd == {REGW{1'b0}}) begin
         hit = 1'b0;
      end else begin
         hit = (rd == rs1) || (rd == rs2);
      end
      return hit;
   endfunction

   // Build the per-stage input records and the upstream-stall vector.
   always_comb begin
      in_ctrl_s  = {ctrl_q[STAGES-2:0],  CtrlD};
      in_rd_s    = {rd_q[STAGES-2:0],    RdD};
      in_valid_s = {valid_q[STAGES-2:0], ValidD};
      // An invalid Decode entry must never carry a register write forward.
      in_rw_s    = {rw_q[STAGES-2:0],    (RegWriteD & ValidD)};
      up_stall_s = {StallS[STAGES-2:0],  1'b0};
   end

   // Next-state selection per stage: stall > flush > auto-bubble > load.
   always_comb begin
      ctrl_d       = ctrl_q;
      rd_d         = rd_q;
      valid_d      = valid_q;
      rw_d         = rw_q;
      bubble_evt_s = 1'b0;
      for (int i = 0; i < STAGES; i++) begin
         if (StallS[i]) begin
            // Hold: a flush is ignored while the stage is stalled.
            ctrl_d[i]  = ctrl_q[i];
            rd_d[i]    = rd_q[i];
            valid_d[i] = valid_q[i];
            rw_d[i]    = rw_q[i];
         end else if (FlushS[i] || up_stall_s[i]) begin
            // Flush bubble, or auto bubble because the upstream entry stays put.
            ctrl_d[i]  = {CTRLW{1'b0}};
            rd_d[i]    = {REGW{1'b0}};
            valid_d[i] = 1'b0;
            rw_d[i]    = 1'b0;
            if (i > 0) begin
               bubble_evt_s = 1'b1;
            end else begin
               bubble_evt_s = bubble_evt_s;
            end
         end else begin
            ctrl_d[i]  = in_ctrl_s[i];
            rd_d[i]    = in_rd_s[i];
            valid_d[i] = in_valid_s[i];
            rw_d[i]    = in_rw_s[i];
         end
      end
   end

   // Retirement: valid entry leaves the last stage when it is not stalled.
   always_comb begin
      retire_evt_s = valid_q[STAGES-1] & ~StallS[STAGES-1];
   end

   // Stage registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_q  <= '0;
         rd_q    <= '0;
         valid_q <= '0;
         rw_q    <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         rd_q    <= rd_d;
         valid_q <= valid_d;
         rw_q    <= rw_d;
      end
   end

   // Output mapping straight from the stage registers.
   always_comb begin
      CtrlS     = ctrl_q;
      RdS       = rd_q;
      ValidS    = valid_q;
      RegWriteS = rw_q;
   end

   // Load-use hazard: valid load in Execute writing a register Decode reads.
   always_comb begin
      if (valid_q[0] && ctrl_q[0][MEMRDBIT] && rw_q[0]) begin
         LoadUseStallD = rd_hits(rd_q[0], Rs1D, Rs2D);
      end else begin
         LoadUseStallD = 1'b0;
      end
   end

   // Pending indication: PENDBIT in a valid Decode entry or any valid stage.
   always_comb begin
      PendingD = CtrlD[PENDBIT] & ValidD;
      for (int i = 0; i < STAGES; i++) begin
         if (valid_q[i] && ctrl_q[i][PENDBIT]) begin
            PendingD = 1'b1;
         end else begin
            PendingD = PendingD;
         end
      end
   end

`ifdef CTRL_PIPE_PERF_EN
   logic [31:0] bubble_cnt_q, bubble_cnt_d;
   logic [31:0] retire_cnt_q, retire_cnt_d;

   // Saturating performance counter next-state.
   always_comb begin
      bubble_cnt_d = sat_inc(bubble_cnt_q, bubble_evt_s);
      retire_cnt_d = sat_inc(retire_cnt_q, retire_evt_s);
   end

   // Performance counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bubble_cnt_q <= 32'd0;
         retire_cnt_q <= 32'd0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   // Counter outputs.
   always_comb begin
      BubbleCount = bubble_cnt_q;
      RetireCount = retire_cnt_q;
   end
`else
   // Event strobes have no consumer when the counters are not built.
   logic unused_evt_s;
   always_comb begin
      unused_evt_s = bubble_evt_s ^ retire_evt_s;
   end
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
//------------------------------------------------------------------------------
// tb_ctrl_pipe: directed and randomized checks of ctrl_pipe against a
// record-level reference model (array of {ctrl, valid, rd, regwrite}).
//------------------------------------------------------------------------------
module tb_ctrl_pipe;
   localparam int STAGES   = 3;
   localparam int CTRLW    = 27;
   localparam int REGW     = 5;
   localparam int PENDBIT  = 0;
   localparam int MEMRDBIT = 1;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [STAGES-1:0]        StallS, FlushS;
   logic [CTRLW-1:0]         CtrlD;
   logic                     ValidD;
   logic [REGW-1:0]          RdD, Rs1D, Rs2D;
   logic                     RegWriteD;
   logic [STAGES*CTRLW-1:0]  CtrlS;
   logic [STAGES-1:0]        ValidS;
   logic [STAGES*REGW-1:0]   RdS;
   logic [STAGES-1:0]        RegWriteS;
   logic                     LoadUseStallD, PendingD;
`ifdef CTRL_PIPE_PERF_EN
   logic [31:0]              BubbleCount, RetireCount;
`endif

   ctrl_pipe #(.STAGES(STAGES), .CTRLW(CTRLW), .REGW(REGW),
               .PENDBIT(PENDBIT), .MEMRDBIT(MEMRDBIT)) dut (
      .clk(clk), .reset(reset), .StallS(StallS), .FlushS(FlushS),
      .CtrlD(CtrlD), .ValidD(ValidD), .RdD(RdD), .RegWriteD(RegWriteD),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .CtrlS(CtrlS), .ValidS(ValidS), .RdS(RdS),
      .RegWriteS(RegWriteS), .LoadUseStallD(LoadUseStallD), .PendingD(PendingD)
`ifdef CTRL_PIPE_PERF_EN
      , .BubbleCount(BubbleCount), .RetireCount(RetireCount)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CTRLW-1:0] ctrl;
      logic             v;
      logic [REGW-1:0]  rd;
      logic             rw;
   } rec_t;

   rec_t        m [STAGES];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_bub, m_ret;

   function automatic rec_t zero_rec();
      rec_t r;
      r.ctrl = '0; r.v = 1'b0; r.rd = '0; r.rw = 1'b0;
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < STAGES; i++) m[i] = zero_rec();
      m_bub = 32'd0;
      m_ret = 32'd0;
   endtask

   // One rising edge applied to the model, following the priority rules.
   task automatic model_edge();
      rec_t nxt [STAGES];
      bit   bub;
      bit   ret;
      bub = 1'b0;
      ret = m[STAGES-1].v && !StallS[STAGES-1];
      for (int i = 0; i < STAGES; i++) begin
         if (StallS[i]) nxt[i] = m[i];
         else if (FlushS[i]) begin
            nxt[i] = zero_rec();
            if (i > 0) bub = 1'b1;
         end else if (i > 0 && StallS[i-1]) begin
            nxt[i] = zero_rec();
            bub = 1'b1;
         end else if (i == 0) begin
            nxt[0].ctrl = CtrlD; nxt[0].v = ValidD; nxt[0].rd = RdD;
            nxt[0].rw = RegWriteD & ValidD;
         end else nxt[i] = m[i-1];
      end
      m = nxt;
      if (bub && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 32'd1;
      if (ret && m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 32'd1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every output with the model (combinational ones use current inputs).
   task automatic check_all(input string tag);
      logic [STAGES*CTRLW-1:0] e_ctrl;
      logic [STAGES*REGW-1:0]  e_rd;
      logic [STAGES-1:0]       e_v, e_rw;
      logic                    e_lu, e_pend;
      for (int i = 0; i < STAGES; i++) begin
         e_ctrl[i*CTRLW +: CTRLW] = m[i].ctrl;
         e_rd[i*REGW +: REGW]     = m[i].rd;
         e_v[i]                   = m[i].v;
         e_rw[i]                  = m[i].rw;
      end
      e_lu = m[0].v && m[0].ctrl[MEMRDBIT] && m[0].rw && (m[0].rd != 0) &&
             (m[0].rd == Rs1D || m[0].rd == Rs2D);
      e_pend = CtrlD[PENDBIT] && ValidD;
      for (int i = 0; i < STAGES; i++) if (m[i].v && m[i].ctrl[PENDBIT]) e_pend = 1'b1;
      chk({tag, ".CtrlS"}, CtrlS, e_ctrl);
      chk({tag, ".ValidS"}, ValidS, e_v);
      chk({tag, ".RdS"}, RdS, e_rd);
      chk({tag, ".RegWriteS"}, RegWriteS, e_rw);
      chk({tag, ".LoadUse"}, LoadUseStallD, e_lu);
      chk({tag, ".Pending"}, PendingD, e_pend);
`ifdef CTRL_PIPE_PERF_EN
      chk({tag, ".BubbleCount"}, BubbleCount, m_bub);
      chk({tag, ".RetireCount"}, RetireCount, m_ret);
`endif
   endtask

   task automatic drive(input logic [CTRLW-1:0] c, input logic v, input logic [REGW-1:0] rd,
                        input logic rw, input logic [STAGES-1:0] st, input logic [STAGES-1:0] fl);
      CtrlD = c; ValidD = v; RdD = rd; RegWriteD = rw; StallS = st; FlushS = fl;
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      // Reset state
      reset = 1'b0;
      drive('0, 1'b0, '0, 1'b0, '0, '0);
      Rs1D = '0; Rs2D = '0;
      model_reset();
      #12;
      check_all("reset");
      chk("reset.ValidS0", ValidS, 3'b000);
      reset = 1'b1;

      // Straight flow: 0xABC, Rd=7 travels one stage per edge
      drive(27'h0000ABC, 1'b1, 5'd7, 1'b1, 3'b000, 3'b000);
      step("flow1");
      chk("flow1.v", ValidS, 3'b001);
      chk("flow1.rd", RdS[4:0], 5'd7);
      drive('0, 1'b0, '0, 1'b0, 3'b000, 3'b000);
      step("flow2");
      chk("flow2.v", ValidS, 3'b010);
      chk("flow2.ctrl", CtrlS[53:27], 27'h0000ABC);
      step("flow3");
      chk("flow3.v", ValidS, 3'b100);
      chk("flow3.rd", RdS[14:10], 5'd7);
      step("flow4");
      chk("flow4.v", ValidS, 3'b000);

      // Auto-bubble: stage 0 stalled twice, stage 1 gets bubbles, A moves once
      drive(27'h0000123, 1'b1, 5'd3, 1'b1, 3'b000, 3'b000);
      step("ab_load");
      drive('0, 1'b0, '0, 1'b0, 3'b001, 3'b000);
      step("ab_st1");
      chk("ab_st1.v", ValidS, 3'b001);
      step("ab_st2");
      chk("ab_st2.v", ValidS, 3'b001);
      chk("ab_st2.ctrl0", CtrlS[26:0], 27'h0000123);
      drive('0, 1'b0, '0, 1'b0, 3'b000, 3'b000);
      step("ab_rel");
      chk("ab_rel.v", ValidS, 3'b010);
      chk("ab_rel.ctrl1", CtrlS[53:27], 27'h0000123);
      step("ab_once");
      chk("ab_once.v", ValidS, 3'b100);

      // Flush vs stall priority on stage 1
      drive(27'h0000055, 1'b1, 5'd9, 1'b1, 3'b000, 3'b000);
      step("fs_load");
      drive('0, 1'b0, '0, 1'b0, 3'b000, 3'b000);
      step("fs_mv");
      drive('0, 1'b0, '0, 1'b0, 3'b010, 3'b010);
      step("fs_hold");
      chk("fs_hold.v1", ValidS[1], 1'b1);
      chk("fs_hold.ctrl1", CtrlS[53:27], 27'h0000055);
      drive('0, 1'b0, '0, 1'b0, 3'b000, 3'b010);
      step("fs_flush");
      chk("fs_flush.v1", ValidS[1], 1'b0);
      chk("fs_flush.ctrl1", CtrlS[53:27], 27'h0);

      // Load-use
      drive(27'h0000002, 1'b1, 5'd5, 1'b1, 3'b000, 3'b000);
      step("lu_load");
      drive('0, 1'b0, '0, 1'b0, 3'b001, 3'b000);
      Rs1D = 5'd5; Rs2D = 5'd0; #1;
      check_all("lu_rs1");
      chk("lu_rs1.hit", LoadUseStallD, 1'b1);
      Rs1D = 5'd6; Rs2D = 5'd6; #1;
      check_all("lu_miss");
      chk("lu_miss.hit", LoadUseStallD, 1'b0);
      Rs1D = 5'd0; Rs2D = 5'd5; #1;
      chk("lu_rs2.hit", LoadUseStallD, 1'b1);
      drive(27'h0000002, 1'b1, 5'd0, 1'b1, 3'b000, 3'b000);
      Rs1D = 5'd0; Rs2D = 5'd0;
      step("lu_x0");
      chk("lu_x0.hit", LoadUseStallD, 1'b0);
      drive(27'h0000000, 1'b1, 5'd5, 1'b1, 3'b000, 3'b000);
      Rs1D = 5'd5;
      step("lu_noload");
      chk("lu_noload.hit", LoadUseStallD, 1'b0);
      Rs1D = 5'd0;

      // Pending from stage 2 only, all-ones stall freeze, then async reset
      drive(27'h0000001, 1'b1, 5'd2, 1'b0, 3'b000, 3'b000);
      step("pd_load");
      drive('0, 1'b0, '0, 1'b0, 3'b000, 3'b000);
      step("pd_mv1");
      step("pd_mv2");
      chk("pd_s2.v", ValidS, 3'b100);
      chk("pd_s2.pend", PendingD, 1'b1);
      drive(27'h7FFFFFF, 1'b1, 5'd31, 1'b1, 3'b111, 3'b111);
      step("freeze");
      chk("freeze.v", ValidS, 3'b100);
      #1 reset = 1'b0;
      #1;
      model_reset();
      drive('0, 1'b0, '0, 1'b0, 3'b111, 3'b000);
      #1;
      chk("rst_mid.v", ValidS, 3'b000);
      chk("rst_mid.pend", PendingD, 1'b0);
      check_all("rst_mid");
      reset = 1'b1;
      drive(27'h0000444, 1'b1, 5'd4, 1'b1, 3'b000, 3'b000);
      step("rst_rel");
      chk("rst_rel.v", ValidS, 3'b001);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic [STAGES-1:0] st, fl;
         for (int b = 0; b < STAGES; b++) begin
            st[b] = ($urandom_range(0, 4) == 0);
            fl[b] = ($urandom_range(0, 7) == 0);
         end
         drive(CTRLW'($urandom), ($urandom_range(0, 3) != 0), REGW'($urandom_range(0, 7)),
               1'($urandom), st, fl);
         Rs1D = REGW'($urandom_range(0, 7));
         Rs2D = REGW'($urandom_range(0, 7));
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
